// File: rtl/router_pkt_tx.sv
// Router input-port packet transmitter: buffers payload bytes, then sends
// header, payload and parity under busy back-pressure, followed by an idle gap.
module router_pkt_tx #(
  parameter int unsigned DEPTH = 63,
  parameter int unsigned IPG   = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic [5:0] count,
  input  logic       start,
  input  logic [1:0] dest_addr,
  input  logic       busy,
  output logic       pkt_valid,
  output logic [7:0] data_out,
  output logic       tx_active,
  output logic       done,
  output logic       err
);

  localparam int unsigned PTR_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int unsigned GAP_W = (IPG < 2) ? 1 : $clog2(IPG + 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PL,
    PAR,
    GAP
  } state_t;

  state_t             state_q, state_n;
  logic [7:0]         mem [DEPTH];
  logic [PTR_W-1:0]   rd_q, rd_n, wr_q, wr_n;
  logic [5:0]         len_q, len_n, rem_q, rem_n, count_n, len_new;
  logic [7:0]         parity_q, parity_n, data_n, head, header;
  logic [GAP_W-1:0]   gap_q, gap_n;
  logic               valid_n, done_n, err_n, full_n, active_n;
  logic               wr_ok, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Payload storage; no reset needed since occupancy gates every read.
  always_ff @(posedge clock) begin
    if (wr_ok) mem[wr_q] <= wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      rd_q      <= '0;
      wr_q      <= '0;
      len_q     <= '0;
      rem_q     <= '0;
      parity_q  <= '0;
      gap_q     <= '0;
      count     <= '0;
      full      <= 1'b0;
      pkt_valid <= 1'b0;
      data_out  <= '0;
      tx_active <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_n;
      rd_q      <= rd_n;
      wr_q      <= wr_n;
      len_q     <= len_n;
      rem_q     <= rem_n;
      parity_q  <= parity_n;
      gap_q     <= gap_n;
      count     <= count_n;
      full      <= full_n;
      pkt_valid <= valid_n;
      data_out  <= data_n;
      tx_active <= active_n;
      done      <= done_n;
      err       <= err_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    rd_n     = rd_q;
    wr_n     = wr_q;
    len_n    = len_q;
    rem_n    = rem_q;
    parity_n = parity_q;
    gap_n    = gap_q;
    data_n   = data_out;
    valid_n  = pkt_valid;
    done_n   = 1'b0;
    pop      = 1'b0;
    head     = mem[rd_q];

    // Writes only land while idle with room; anything else is dropped and flagged.
    wr_ok   = wr_en && (state_q == IDLE) && !full;
    err_n   = wr_en && !wr_ok;
    len_new = count + 6'(wr_ok);
    header  = {len_new, dest_addr};
    if (wr_ok) wr_n = ptr_inc(wr_q);

    case (state_q)
      IDLE: begin
        data_n  = '0;
        valid_n = 1'b0;
        if (start) begin
          if (len_new == '0 || dest_addr == 2'd3) begin
            err_n = 1'b1;
          end else begin
            len_n    = len_new;
            data_n   = header;
            parity_n = header;
            valid_n  = 1'b1;
            state_n  = HDR;
          end
        end
      end
      HDR: begin
        if (!busy) begin
          pop      = 1'b1;
          data_n   = head;
          parity_n = parity_q ^ head;
          rem_n    = len_q - 6'd1;
          state_n  = PL;
        end
      end
      PL: begin
        if (!busy) begin
          if (rem_q != '0) begin
            pop      = 1'b1;
            data_n   = head;
            parity_n = parity_q ^ head;
            rem_n    = rem_q - 6'd1;
          end else begin
            data_n  = parity_q;
            valid_n = 1'b0;
            state_n = PAR;
          end
        end
      end
      PAR: begin
        if (!busy) begin
          data_n = '0;
          if (IPG == 0) begin
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            gap_n   = GAP_W'(IPG);
            state_n = GAP;
          end
        end
      end
      GAP: begin
        // Gap ignores busy; done coincides with the return to idle.
        gap_n = gap_q - GAP_W'(1);
        if (gap_q == GAP_W'(1)) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (pop) rd_n = ptr_inc(rd_q);

    case ({wr_ok, pop})
      2'b10:   count_n = count + 6'd1;
      2'b01:   count_n = count - 6'd1;
      default: count_n = count;
    endcase
    full_n   = (count_n == 6'(DEPTH));
    active_n = (state_n != IDLE);
  end

endmodule
